uart_tx: RTL
============

Name: uart_tx

Overview:
UART-style serial transmitter. It accepts a parallel byte over a valid/ready handshake and shifts it out on a single line as start bit, LSB-first data, then stop bit. It is the transmit end of the SoC's serial link. It feeds the board-level TX pin or the loopback path to the matching receive logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit period; legal range >= 1.
DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
clk       input   1          system clock; all state updates on rising edge
rst_n     input   1          asynchronous active-low reset
tx_data   input   DATA_BITS  parallel word to send; sampled only on handshake
tx_valid  input   1          upstream has a word on tx_data
tx_ready  output  1          block can accept a word this cycle
tx        output  1          serial line; idle high
busy      output  1          frame in progress (START, DATA or STOP state)

Behaviour:
- Reset:
  - Single clock `clk`; reset `rst_n` is asynchronous, active-low.
  - While rst_n=0, state is IDLE, tx=1, tx_ready=1, busy=0.
  - Bit counter, cycle counter and shift register all clear to 0.
- Outputs:
  - tx, tx_ready and busy are driven from registers or decoded from registered state only.
  - No combinational path runs from any input to any output.
- States: IDLE, START, DATA, STOP.
  - IDLE: tx=1, tx_ready=1, busy=0.
  - Handshake fires at a rising edge where tx_valid=1 and tx_ready=1.
  - At that edge: latch tx_data into the shift register, clear the cycle counter, go to START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles per bit.
  - At each bit boundary, shift right and increment the bit index.
  - After DATA_BITS bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- During START, DATA and STOP: tx_ready=0 and busy=1.
- Timing:
  - tx falls on the first clock edge after the handshake edge.
  - Line activity is (DATA_BITS+2)*CLKS_PER_BIT cycles per frame.
  - Exactly one IDLE cycle (tx=1, tx_ready=1) follows each frame.
  - With tx_valid held high, back-to-back frames start every (DATA_BITS+2)*CLKS_PER_BIT+1 cycles.
- Cycle counter:
  - Width is $clog2(CLKS_PER_BIT) bits, with a minimum of 1.
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 at each bit boundary.
  - CLKS_PER_BIT=1 gives one cycle per bit; the counter is unused but legal.
- Bit index width is $clog2(DATA_BITS+1).
- tx_data and tx_valid are ignored outside IDLE. Changes to tx_data mid-frame do not affect the frame being sent.
- tx_valid deasserted in IDLE: remain in IDLE indefinitely with tx=1.
- Reset asserted mid-frame:
  - Immediately (asynchronously) return to IDLE with tx=1, tx_ready=1, busy=0.
  - The partial frame is abandoned and not resumed after reset release.
  - The first handshake after release starts a clean frame.
- No parity and no break generation.
- X on tx_data outside the handshake cycle must not propagate to tx.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, then release with tx_valid=0 -> tx=1, tx_ready=1, busy=0 for 20 cycles; no activity.
2. Single frame, CLKS_PER_BIT=4, DATA_BITS=8, send 0xA5 -> tx sequence 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each level held 4 cycles. tx_ready=0 for exactly 40 cycles, then 1.
3. Back-to-back: hold tx_valid=1 with 0x00 then 0xFF -> second start bit falls exactly 41 cycles after the first; one tx=1 idle cycle between the frames.
4. Data change mid-frame: send 0x3C, then drive tx_data=0xFF with tx_valid=1 during DATA -> line carries 0x3C. 0xFF is accepted only at the next IDLE cycle.
5. Async reset mid-frame: assert rst_n=0 between clock edges during bit 3 of 0x55 -> tx=1 and tx_ready=1 before the next rising edge. A new 0x81 after release transmits a correct full frame.
6. Edge parameters: CLKS_PER_BIT=1, DATA_BITS=5, send 0x15 -> 7-cycle frame 0,1,0,1,0,1,1; the next frame can start on cycle 8.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop bit on tx.
// Latency: tx falls in the cycle after the accepting edge; frame is (DATA_BITS+2)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready is high only in IDLE, so one word is accepted per frame plus one idle cycle.
module uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   // Cycle counter needs at least one bit even when each bit lasts one clock.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 bit_end;

   // Last cycle of the current serial bit period.
   assign bit_end = (cnt_q == CNT_LAST);

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Next-state logic: accept in IDLE, then walk START -> DATA x DATA_BITS -> STOP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            // tx_ready is implied by IDLE, so tx_valid alone completes the handshake.
            if (tx_valid) begin
               shift_d = tx_data;
               cnt_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + BW'(1);
               if (bit_q == BIT_LAST) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only; shift_q reaches tx only while in DATA.
   always_comb begin
      tx       = 1'b1;
      tx_ready = (state_q == S_IDLE);
      busy     = (state_q != S_IDLE);
      if (state_q == S_START) begin
         tx = 1'b0;
      end else if (state_q == S_DATA) begin
         tx = shift_q[0];
      end
   end

endmodule
